downsample_2: RTL and testbench

Decimate-by-2 stage for the wavelet analysis path. It accepts a filtered sample stream with a valid strobe and keeps one sample out of every two accepted samples; the kept phase is selectable. Kept samples are buffered in a small first-word-fall-through FIFO with a valid/ready output handshake, so a stalled downstream stage does not lose alignment. It is the receive-side counterpart of `upsample_2` and sits between the analysis filter and the next decomposition level or the capture logic.

---
 rtl/downsample_2_if.sv | 26 ++
 rtl/downsample_2.sv | 68 ++++++
 tb/tb_downsample_2.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/downsample_2_if.sv
// Sample-stream bundle for the decimate-by-2 stage: unthrottled input strobe,
// valid/ready output handshake, plus status.
interface downsample_2_if #(
    parameter int ADC_WIDTH  = 14,
    parameter int FIFO_DEPTH = 4
);
    logic [ADC_WIDTH-1:0]            adc_data_in;
    logic                            in_valid;
    logic                            phase_sel;
    logic                            sync;
    logic [ADC_WIDTH-1:0]            adc_data_out;
    logic                            out_valid;
    logic                            out_ready;
    logic [$clog2(FIFO_DEPTH):0]     fifo_level;
    logic                            overflow;

    modport master (
        output adc_data_in, in_valid, phase_sel, sync, out_ready,
        input  adc_data_out, out_valid, fifo_level, overflow
    );

    modport slave (
        input  adc_data_in, in_valid, phase_sel, sync, out_ready,
        output adc_data_out, out_valid, fifo_level, overflow
    );
endinterface

// File: rtl/downsample_2.sv
// Decimate-by-2: keeps one of every two valid samples (selectable phase) and
// buffers kept samples in a first-word-fall-through FIFO.
module downsample_2 #(
    parameter int ADC_WIDTH  = 14,
    parameter int FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    downsample_2_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    logic                 phase;
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level;
    logic                 ovf;
    logic [ADC_WIDTH-1:0] mem [FIFO_DEPTH];

    logic eff_phase, keep, pop, full, push, drop;

    // A sync pulse forces the sample in the same cycle to be phase 0.
    assign eff_phase = bus.sync ? 1'b0 : phase;
    assign keep      = bus.in_valid && (eff_phase == bus.phase_sel);
    assign pop       = (level != '0) && bus.out_ready;
    assign full      = (level == LW'(FIFO_DEPTH));
    assign push      = keep && (!full || pop);
    assign drop      = keep && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 1'b0;
        end else if (bus.sync) begin
            phase <= bus.in_valid;
        end else if (bus.in_valid) begin
            phase <= ~phase;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.adc_data_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    // Set wins over a simultaneous sync clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           ovf <= 1'b0;
        else if (drop)     ovf <= 1'b1;
        else if (bus.sync) ovf <= 1'b0;
    end

    assign bus.adc_data_out = mem[rd_ptr];
    assign bus.out_valid    = (level != '0);
    assign bus.fifo_level   = level;
    assign bus.overflow     = ovf;
endmodule

// File: tb/tb_downsample_2.sv
// Bench for downsample_2: directed scenarios from the block's use cases plus a
// randomized run against a queue-based reference model.
module tb_downsample_2;
    localparam int AW = 14;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [AW-1:0] got[$];

    always #5 clk = ~clk;

    downsample_2_if #(.ADC_WIDTH(AW), .FIFO_DEPTH(DEPTH)) bus ();
    downsample_2 #(.ADC_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Drive one cycle; log any handshake that completes at this edge.
    task automatic step(input int d, input logic v, input logic ps, input logic sy, input logic rdy);
        bus.adc_data_in = AW'(d);
        bus.in_valid    = v;
        bus.phase_sel   = ps;
        bus.sync        = sy;
        bus.out_ready   = rdy;
        if (bus.out_valid === 1'b1 && rdy) got.push_back(bus.adc_data_out);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.adc_data_in = '0; bus.in_valid = 0; bus.phase_sel = 0;
        bus.sync = 0; bus.out_ready = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        got.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks += 4;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        if (bus.fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d want=0", bus.fifo_level); end
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b want=0", bus.overflow); end
        if (bus.adc_data_out !== 14'd0) begin failures++; $display("FAIL reset_data got=%0d want=0", bus.adc_data_out); end
    endtask

    task automatic test_even();
        int exp[4] = '{1, 3, 5, 7};
        int maxlvl = 0;
        do_reset();
        step(1, 1, 0, 0, 1);
        checks += 2;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL even_latency_valid got=%b want=1", bus.out_valid); end
        if (bus.adc_data_out !== 14'd1) begin failures++; $display("FAIL even_latency_data got=%0d want=1", bus.adc_data_out); end
        for (int i = 2; i <= 8; i++) begin
            step(i, 1, 0, 0, 1);
            if (int'(bus.fifo_level) > maxlvl) maxlvl = int'(bus.fifo_level);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        checks += 2;
        if (maxlvl > 1) begin failures++; $display("FAIL even_level_max got=%0d want<=1", maxlvl); end
        if (got.size() != 4) begin failures++; $display("FAIL even_count got=%0d want=4", got.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (int'(got[i]) != exp[i]) begin failures++; $display("FAIL even_out[%0d] got=%0d want=%0d", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_odd_gaps();
        int exp[4] = '{2, 4, 6, 8};
        int din[6] = '{10, -1, 11, -1, 12, 13};
        do_reset();
        for (int i = 1; i <= 8; i++) step(i, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1);
        checks++;
        if (got.size() != 4) begin failures++; $display("FAIL odd_count got=%0d want=4", got.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (int'(got[i]) != exp[i]) begin failures++; $display("FAIL odd_out[%0d] got=%0d want=%0d", i, got[i], exp[i]); end
        end
        do_reset();
        foreach (din[i]) step(din[i] < 0 ? 0 : din[i], din[i] >= 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        checks++;
        if (got.size() != 2 || got[0] !== 14'd10 || got[1] !== 14'd12) begin
            failures++;
            $display("FAIL gaps_out got_n=%0d first=%0d second=%0d want=10,12", got.size(),
                     got.size() > 0 ? got[0] : 0, got.size() > 1 ? got[1] : 0);
        end
    endtask

    task automatic test_sync();
        int exp[4] = '{1, 3, 4, 6};
        do_reset();
        for (int i = 1; i <= 6; i++) step(i, 1, 0, i == 4, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        checks++;
        if (got.size() != 4) begin failures++; $display("FAIL sync_count got=%0d want=4", got.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (int'(got[i]) != exp[i]) begin failures++; $display("FAIL sync_out[%0d] got=%0d want=%0d", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_overflow();
        int exp[4] = '{1, 3, 5, 7};
        do_reset();
        for (int i = 1; i <= 12; i++) step(i, 1, 0, 0, 0);
        checks += 3;
        if (bus.fifo_level !== 3'd4) begin failures++; $display("FAIL ovf_level got=%0d want=4", bus.fifo_level); end
        if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b want=1", bus.overflow); end
        if (bus.adc_data_out !== 14'd1) begin failures++; $display("FAIL ovf_head got=%0d want=1", bus.adc_data_out); end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
        checks += 3;
        if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b want=1", bus.overflow); end
        if (bus.fifo_level !== 3'd0) begin failures++; $display("FAIL ovf_drained got=%0d want=0", bus.fifo_level); end
        if (got.size() != 4) begin failures++; $display("FAIL ovf_count got=%0d want=4", got.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (int'(got[i]) != exp[i]) begin failures++; $display("FAIL ovf_out[%0d] got=%0d want=%0d", i, got[i], exp[i]); end
        end
        step(0, 0, 0, 1, 1);
        checks++;
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_sync_clear got=%b want=0", bus.overflow); end
    endtask

    task automatic test_push_pop_full();
        int exp[4] = '{3, 5, 7, 9};
        do_reset();
        for (int i = 1; i <= 8; i++) step(i, 1, 0, 0, 0);
        step(9, 1, 0, 0, 1);
        checks += 3;
        if (bus.fifo_level !== 3'd4) begin failures++; $display("FAIL pp_level got=%0d want=4", bus.fifo_level); end
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL pp_overflow got=%b want=0", bus.overflow); end
        if (bus.adc_data_out !== 14'd3) begin failures++; $display("FAIL pp_head got=%0d want=3", bus.adc_data_out); end
        got.delete();
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
        checks++;
        if (got.size() != 4) begin failures++; $display("FAIL pp_count got=%0d want=4", got.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (int'(got[i]) != exp[i]) begin failures++; $display("FAIL pp_out[%0d] got=%0d want=%0d", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 1; i <= 12; i++) step(i, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        checks += 2;
        if (bus.fifo_level !== 3'd3) begin failures++; $display("FAIL ar_pre_level got=%0d want=3", bus.fifo_level); end
        if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ar_pre_ovf got=%b want=1", bus.overflow); end
        bus.out_ready = 0;
        #3 rst = 1'b1;
        #1;
        checks += 4;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got=%b want=0", bus.out_valid); end
        if (bus.fifo_level !== 3'd0) begin failures++; $display("FAIL ar_level got=%0d want=0", bus.fifo_level); end
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ar_ovf got=%b want=0", bus.overflow); end
        if (bus.adc_data_out !== 14'd0) begin failures++; $display("FAIL ar_data got=%0d want=0", bus.adc_data_out); end
        #2 rst = 1'b0;
        got.delete();
        step(20, 1, 0, 0, 1);
        step(21, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        checks++;
        if (got.size() != 1 || got[0] !== 14'd20) begin
            failures++;
            $display("FAIL ar_after got_n=%0d first=%0d want=20", got.size(), got.size() > 0 ? got[0] : 0);
        end
    endtask

    // Reference: count valid samples since the last realign; keep when that
    // index's parity matches phase_sel; FIFO is a bounded queue.
    task automatic test_random();
        int mq[$];
        int cnt = 0;
        bit ovf = 0;
        bit ps = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            int d = $urandom_range(0, 16383);
            bit v = ($urandom_range(0, 3) != 0);
            bit sy = ($urandom_range(0, 24) == 0);
            bit rdy = ($urandom_range(0, 2) == 0) ^ (c >= 300);
            bit keep, pop;
            if ($urandom_range(0, 19) == 0) ps = ~ps;
            pop  = (mq.size() > 0) && rdy;
            keep = v && (((sy ? 0 : cnt) % 2) == ps);
            step(d, v, ps, sy, rdy);
            if (pop) void'(mq.pop_front());
            if (sy) ovf = 0;
            if (keep) begin
                if (mq.size() < DEPTH) mq.push_back(d);
                else ovf = 1;
            end
            if (sy) cnt = v ? 1 : 0;
            else if (v) cnt++;
            checks += 3;
            if (bus.out_valid !== (mq.size() > 0)) begin failures++; $display("FAIL rnd_valid c=%0d got=%b want=%0d", c, bus.out_valid, mq.size() > 0); end
            if (int'(bus.fifo_level) != mq.size()) begin failures++; $display("FAIL rnd_level c=%0d got=%0d want=%0d", c, bus.fifo_level, mq.size()); end
            if (bus.overflow !== ovf) begin failures++; $display("FAIL rnd_ovf c=%0d got=%b want=%b", c, bus.overflow, ovf); end
            if (mq.size() > 0) begin
                checks++;
                if (int'(bus.adc_data_out) != mq[0]) begin failures++; $display("FAIL rnd_data c=%0d got=%0d want=%0d", c, bus.adc_data_out, mq[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_even();
        test_odd_gaps();
        test_sync();
        test_overflow();
        test_push_pop_full();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
